// File: rtl/pc_redirect_unit_pkg.sv
// Shared decode constants and next-PC select encoding for the PC redirect unit.
package pc_pkg;

    localparam logic [5:0] FUNCT_JR       = 6'b001000;
    localparam int         RA_REG_DEFAULT = 31;

    typedef enum logic [1:0] {
        SEL_JR,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_SEQ
    } next_sel_e;

endpackage

// File: rtl/pc_redirect_unit_ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten when full, and an
// empty pop is ignored. A simultaneous push and pop replaces the top entry in place.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;
    logic             do_pop;

    // ptr_q names the next free slot; the top lives one below it (mod DEPTH).
    assign top_idx = ptr_q - PTR_W'(1);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && do_pop) begin
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[top_idx];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_redirect_unit.sv
// Next-PC unit: PC register, one-level redirect priority mux, return-address stack
// and a saturating counter of return mispredictions.
module pc_redirect_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RA_REG    = RA_REG_DEFAULT,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             JR,
    input  logic [5:0]       Funct,
    input  logic [4:0]       Rs,
    input  logic [WIDTH-1:0] RD1,
    input  logic             JAL,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_plus4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jr_ev, ret_ev;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top_raw;
    next_sel_e        sel;

    assign jr_ev    = JR && (Funct == FUNCT_JR);
    assign ret_ev   = jr_ev && (Rs == 5'(RA_REG));
    assign PC_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        sel = SEL_SEQ;
        if (jr_ev)              sel = SEL_JR;
        else if (JAL || Jump)   sel = SEL_JUMP;
        else if (BranchTaken)   sel = SEL_BRANCH;
    end

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            unique case (sel)
                SEL_JR:     pc_d = RD1;
                SEL_JUMP:   pc_d = JumpTarget;
                SEL_BRANCH: pc_d = BranchTarget;
                default:    pc_d = PC_plus4;
            endcase
        end
    end

    assign ras_push = JAL && !stall;
    assign ras_pop  = ret_ev && !stall;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (PC_plus4),
        .top       (ras_top_raw),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // The stack is advisory: a wrong prediction is only counted, never acted on.
    always_comb begin
        cnt_d = cnt_q;
        if (ras_pop && !ras_empty && (ras_top_raw != RD1) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign PC             = pc_q;
    assign ras_top        = ras_empty ? RESET_PC : ras_top_raw;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; counter width is narrowed so saturation is reachable.
module tb_pc_redirect_unit;

    localparam int W    = 32;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          JR;
    logic [5:0]    Funct;
    logic [4:0]    Rs;
    logic [W-1:0]  RD1;
    logic          JAL;
    logic          Jump;
    logic [W-1:0]  JumpTarget;
    logic          BranchTaken;
    logic [W-1:0]  BranchTarget;
    logic [W-1:0]  PC;
    logic [W-1:0]  PC_plus4;
    logic [W-1:0]  ras_top;
    logic          ras_empty;
    logic          ras_full;
    logic [CW-1:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    pc_redirect_unit #(
        .WIDTH     (W),
        .RAS_DEPTH (4),
        .RESET_PC  ('0),
        .RA_REG    (31),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .JR             (JR),
        .Funct          (Funct),
        .Rs             (Rs),
        .RD1            (RD1),
        .JAL            (JAL),
        .Jump           (Jump),
        .JumpTarget     (JumpTarget),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .PC             (PC),
        .PC_plus4       (PC_plus4),
        .ras_top        (ras_top),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; JR = 0; Funct = 6'h00; Rs = 5'd0; RD1 = '0;
        JAL = 0; Jump = 0; JumpTarget = '0; BranchTaken = 0; BranchTarget = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic do_jal(input logic [W-1:0] tgt);
        JAL = 1; JumpTarget = tgt;
        step();
    endtask

    task automatic do_ret(input logic [W-1:0] ra);
        JR = 1; Funct = 6'h08; Rs = 5'd31; RD1 = ra;
        step();
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_pc;
        do_reset();
        checks++;
        if (PC !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || mispredict_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset: PC=%h empty=%b full=%b cnt=%0d, want 0 1 0 0", PC, ras_empty, ras_full, mispredict_cnt);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 32'(4 * i);
            checks++;
            if (PC !== exp_pc || ras_empty !== 1'b1 || mispredict_cnt !== 3'd0) begin
                errors++;
                $display("FAIL seq_%0d: PC=%h empty=%b cnt=%0d, want %h 1 0", i, PC, ras_empty, mispredict_cnt, exp_pc);
            end
        end
    endtask

    task automatic test_call_return();
        step();
        checks++;
        if (PC !== 32'h10) begin
            errors++;
            $display("FAIL pc_0x10: PC=%h want 00000010", PC);
        end
        do_jal(32'h100);
        checks++;
        if (PC !== 32'h100 || ras_top !== 32'h14 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL jal_push: PC=%h top=%h empty=%b, want 100 14 0", PC, ras_top, ras_empty);
        end
        do_ret(32'h14);
        checks++;
        if (PC !== 32'h14 || ras_empty !== 1'b1 || mispredict_cnt !== 3'd0 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL ret_pop: PC=%h empty=%b cnt=%0d top=%h, want 14 1 0 0", PC, ras_empty, mispredict_cnt, ras_top);
        end
    endtask

    task automatic test_ras_overflow();
        logic [W-1:0] ra;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            do_jal(32'(i * 32'h100));
        end
        checks++;
        if (ras_full !== 1'b1 || ras_top !== 32'h404 || PC !== 32'h500) begin
            errors++;
            $display("FAIL ras_full: full=%b top=%h PC=%h, want 1 404 500", ras_full, ras_top, PC);
        end
        for (int i = 4; i >= 1; i--) begin
            ra = 32'(i * 32'h100 + 4);
            checks++;
            if (ras_top !== ra) begin
                errors++;
                $display("FAIL drain_top_%0d: top=%h want %h", i, ras_top, ra);
            end
            do_ret(ra);
        end
        checks++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || mispredict_cnt !== 3'd0) begin
            errors++;
            $display("FAIL drained: empty=%b full=%b cnt=%0d, want 1 0 0", ras_empty, ras_full, mispredict_cnt);
        end
        do_ret(32'h4);
        checks++;
        if (PC !== 32'h4 || ras_empty !== 1'b1 || mispredict_cnt !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop: PC=%h empty=%b cnt=%0d, want 4 1 0", PC, ras_empty, mispredict_cnt);
        end
    endtask

    task automatic test_mispredict();
        logic [CW-1:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        do_jal(32'h200);
        do_ret(32'h80);
        checks++;
        if (PC !== 32'h80 || mispredict_cnt !== 3'd1 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL mispredict: PC=%h cnt=%0d empty=%b, want 80 1 1", PC, mispredict_cnt, ras_empty);
        end
        exp_cnt = 3'd1;
        for (int i = 0; i < 8; i++) begin
            do_jal(32'h200);
            do_ret(32'h80);
            if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
        end
        checks++;
        if (mispredict_cnt !== exp_cnt || exp_cnt !== 3'd7) begin
            errors++;
            $display("FAIL saturate: cnt=%0d want 7", mispredict_cnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        JR = 1; Funct = 6'h08; Rs = 5'd3; RD1 = 32'h40;
        Jump = 1; JumpTarget = 32'h50; BranchTaken = 1; BranchTarget = 32'h60;
        step();
        checks++;
        if (PC !== 32'h40 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL prio_jr: PC=%h empty=%b, want 40 1", PC, ras_empty);
        end
        JR = 1; Funct = 6'h20; Rs = 5'd31; RD1 = 32'h40;
        Jump = 1; JumpTarget = 32'h50; BranchTaken = 1; BranchTarget = 32'h60;
        step();
        checks++;
        if (PC !== 32'h50) begin
            errors++;
            $display("FAIL prio_jump: PC=%h want 50", PC);
        end
        BranchTaken = 1; BranchTarget = 32'h60;
        step();
        checks++;
        if (PC !== 32'h60) begin
            errors++;
            $display("FAIL branch: PC=%h want 60", PC);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_jal(32'h100);
        JR = 1; Funct = 6'h08; Rs = 5'd5; RD1 = 32'h300;
        step();
        checks++;
        if (PC !== 32'h300 || ras_top !== 32'h4 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL nonret_jr: PC=%h top=%h empty=%b, want 300 4 0", PC, ras_top, ras_empty);
        end
        JAL = 1; JumpTarget = 32'h900; JR = 1; Funct = 6'h08; Rs = 5'd31; RD1 = 32'h4;
        step();
        checks++;
        if (PC !== 32'h4 || ras_top !== 32'h304 || mispredict_cnt !== 3'd0 || ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL jal_ret: PC=%h top=%h cnt=%0d empty=%b, want 4 304 0 0", PC, ras_top, mispredict_cnt, ras_empty);
        end
        do_ret(32'h304);
        checks++;
        if (ras_empty !== 1'b1 || mispredict_cnt !== 3'd0) begin
            errors++;
            $display("FAIL jal_ret_depth: empty=%b cnt=%0d, want 1 0", ras_empty, mispredict_cnt);
        end
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step();
        checks++;
        if (PC !== 32'hFFFF_FFFC || PC_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap: PC=%h plus4=%h, want fffffffc 0", PC, PC_plus4);
        end
        step();
        checks++;
        if (PC !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: PC=%h want 0", PC);
        end
    endtask

    task automatic test_stall();
        do_reset();
        do_jal(32'h100);
        do_jal(32'h200);
        do_ret(32'h999);
        for (int i = 0; i < 3; i++) begin
            stall = 1; JAL = 1; JumpTarget = 32'h700; BranchTaken = 1; BranchTarget = 32'h800;
            JR = 1; Funct = 6'h08; Rs = 5'd31; RD1 = 32'h55;
            step();
            checks++;
            if (PC !== 32'h999 || ras_top !== 32'h4 || ras_empty !== 1'b0 || mispredict_cnt !== 3'd1) begin
                errors++;
                $display("FAIL stall_%0d: PC=%h top=%h empty=%b cnt=%0d, want 999 4 0 1", i, PC, ras_top, ras_empty, mispredict_cnt);
            end
        end
        rst_n = 0; stall = 1; JAL = 1; JumpTarget = 32'h700;
        step();
        rst_n = 1;
        checks++;
        if (PC !== 32'h0 || ras_empty !== 1'b1 || mispredict_cnt !== 3'd0) begin
            errors++;
            $display("FAIL stall_reset: PC=%h empty=%b cnt=%0d, want 0 1 0", PC, ras_empty, mispredict_cnt);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_call_return();
        test_ras_overflow();
        test_mispredict();
        test_priority();
        test_back_to_back();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Parametrised next-PC unit, the successor to the single-cycle jump-register mux. It owns the PC register and selects the next PC: jump-register, jump/JAL, taken branch or sequential PC+4. It adds a circular return-address stack (RAS) that is pushed on JAL and popped on `jr $ra`. The RAS top is checked against the register-file value to count return mispredictions. It sits between the control unit / register file and instruction memory.

Parameters:
WIDTH, 32, PC and data width in bits (multiple of 8, ≥8)
RAS_DEPTH, 4, RAS entries (power of two, 2..16)
RESET_PC, 0, PC value loaded on reset
RA_REG, 31, register index treated as the return-address register
CNT_W, 16, width of the mispredict counter

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  1 = hold PC and RAS, ignore all redirects
JR  input  1  control: jump-register class instruction
Funct  input  6  instruction funct field
Rs  input  5  instruction rs field
RD1  input  WIDTH  register-file read data for rs
JAL  input  1  jump-and-link
Jump  input  1  plain jump
JumpTarget  input  WIDTH  precomputed jump target
BranchTaken  input  1  branch condition resolved true
BranchTarget  input  WIDTH  precomputed branch target
PC  output  WIDTH  current PC (registered)
PC_plus4  output  WIDTH  PC+4, combinational, modulo 2^WIDTH
ras_top  output  WIDTH  current RAS top; RESET_PC when the RAS is empty
ras_empty  output  1  RAS entry count == 0
ras_full  output  1  RAS entry count == RAS_DEPTH
mispredict_cnt  output  CNT_W  saturating count of return mispredicts

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-low `rst_n`, sampled on the rising edge.
- Reset values: PC=RESET_PC; RAS pointer=0; RAS count=0; ras_empty=1; ras_full=0; mispredict_cnt=0. RAS entry contents are don't-care. Reset overrides stall.
- Decode: jr_ev = JR && Funct==6'b001000. ret_ev = jr_ev && Rs==RA_REG.
- Next-PC priority, one level only:
  1. jr_ev → RD1
  2. else JAL or Jump → JumpTarget
  3. else BranchTaken → BranchTarget
  4. else PC_plus4
- Latency: the selected value appears on PC one cycle after the edge at which it is sampled. No bubbles are inserted.
- Stall: when stall=1, PC, RAS and counter all hold, regardless of any other input.
- Push (JAL, not stalled): write PC_plus4 at the pointer; pointer increments modulo RAS_DEPTH; count = min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten (circular) and ras_full stays 1.
- Pop (ret_ev, not stalled, count>0): pointer decrements modulo RAS_DEPTH; count decrements. If ras_top != RD1, mispredict_cnt increments, saturating at all-ones. The PC always takes RD1; the RAS is advisory only.
- Pop when empty: RAS unchanged, counter unchanged, PC still takes RD1.
- Non-return JR (Rs != RA_REG): the RAS is untouched.
- JAL and ret_ev in the same cycle (illegal, but defined):
  - PC takes RD1.
  - RAS does pop-then-push: the top entry is replaced by PC_plus4; pointer and count are unchanged; the mispredict compare still happens.
  - When empty, this behaves as a push only.
- Arithmetic: all adds and compares are WIDTH bits and wrap. A PC of all-ones minus 3 gives PC_plus4 = 0.
- Reset asserted mid-sequence: all state returns to reset values on that edge; in-flight redirects are discarded.

Decomposition:
- Shared package `pc_pkg`:
  - FUNCT_JR = 6'b001000
  - default RA_REG
  - next-PC select enum {SEL_JR, SEL_JUMP, SEL_BRANCH, SEL_SEQ}
- Sub-module `ras_stack` (parameters DEPTH, WIDTH):
  - inputs push, pop
  - outputs top, empty, full
  - contains the circular buffer and count
- The top level holds the PC register, priority mux and mispredict counter.

Test Plan:
1. Reset, then 3 unstalled cycles with no control → PC = 0, 4, 8, C; ras_empty=1; mispredict_cnt=0.
2. PC=0x10, JAL with JumpTarget=0x100 → PC=0x100, ras_top=0x14. Then JR, Funct=0x08, Rs=31, RD1=0x14 → PC=0x14, ras_empty=1, cnt=0.
3. RAS_DEPTH=4: five JALs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 → ras_full=1, ras_top=0x404. Four returns with matching RD1 drain the stack; the fifth return is an empty pop with RD1=0x4 → PC=0x4, cnt=0.
4. Push 0x14, then return with RD1=0x80 → PC=0x80, mispredict_cnt=1. Preload the counter near all-ones and repeat → the counter saturates and does not wrap.
5. Priority: JR (Funct=0x08, RD1=0x40), Jump (JumpTarget=0x50) and BranchTaken (BranchTarget=0x60) all set → PC=0x40. JR with Funct=0x20 plus Jump → PC=0x50.
6. stall=1 with JAL and BranchTaken asserted for 3 cycles → PC, RAS and counter unchanged. Then rst_n=0 with stall=1 for one edge → PC=RESET_PC, ras_empty=1.
